// File: rtl/seq_checker.sv
// Sequence checker: locks onto a +1 (mod 2^WIDTH) stream, counts mismatches while locked.
// Optional SEQ_CHK_CAPTURE_EN adds err_got/err_exp capture of the first mismatch.
module seq_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int LOCK_THRESH = 2,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef SEQ_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]     err_got,
    output logic [WIDTH-1:0]     err_exp
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

    localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
    localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

    state_t               r_state, w_state_next;
    logic                 r_ready;
    logic [WIDTH-1:0]     r_expected, w_expected_next;
    logic [3:0]           r_good, w_good_next;
    logic [3:0]           r_bad, w_bad_next;
    logic                 r_err_pulse, w_err_pulse_next;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_count_next;

    logic                 w_accept;
    logic                 w_match;
    logic [WIDTH-1:0]     w_data_inc;
    logic [3:0]           w_good_inc;
    logic [3:0]           w_bad_inc;

    assign w_accept   = in_valid & r_ready;
    assign w_match    = (in_data == r_expected);
    assign w_data_inc = in_data + WIDTH'(1);
    assign w_good_inc = r_good + 4'd1;
    assign w_bad_inc  = r_bad + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_expected  <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ready     <= 1'b1;
            r_expected  <= w_expected_next;
            r_good      <= w_good_next;
            r_bad       <= w_bad_next;
            r_err_pulse <= w_err_pulse_next;
            r_err_count <= w_err_count_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_expected_next  = r_expected;
        w_good_next      = r_good;
        w_bad_next       = r_bad;
        w_err_pulse_next = 1'b0;
        w_err_count_next = r_err_count;
        if (clear) begin
            w_state_next     = ST_IDLE;
            w_expected_next  = '0;
            w_good_next      = '0;
            w_bad_next       = '0;
            w_err_count_next = '0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    w_expected_next = w_data_inc;
                    w_good_next     = '0;
                    w_state_next    = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    // While acquiring, always resync to whatever arrived.
                    w_expected_next = w_data_inc;
                    if (!w_match) begin
                        w_good_next = '0;
                    end else if (w_good_inc == LOCK_T) begin
                        w_state_next = ST_LOCKED;
                        w_good_next  = '0;
                        w_bad_next   = '0;
                    end else begin
                        w_good_next = w_good_inc;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: bad data never moves the expectation while locked.
                    w_expected_next = r_expected + WIDTH'(1);
                    if (w_match) begin
                        w_bad_next = '0;
                    end else begin
                        w_err_pulse_next = 1'b1;
                        if (r_err_count != {ERR_CNT_W{1'b1}})
                            w_err_count_next = r_err_count + ERR_CNT_W'(1);
                        if (w_bad_inc == LOSS_T) begin
                            w_state_next    = ST_ACQUIRE;
                            w_good_next     = '0;
                            w_bad_next      = '0;
                            w_expected_next = w_data_inc;
                        end else begin
                            w_bad_next = w_bad_inc;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign locked    = (r_state == ST_LOCKED);
    assign expected  = r_expected;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

`ifdef SEQ_CHK_CAPTURE_EN
    logic             r_cap_armed;
    logic [WIDTH-1:0] r_err_got;
    logic [WIDTH-1:0] r_err_exp;
    logic             w_err_hit;
    logic             w_new_lock;

    assign w_err_hit  = !clear && w_accept && (r_state == ST_LOCKED) && !w_match;
    assign w_new_lock = (w_state_next == ST_LOCKED) && (r_state != ST_LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_armed <= 1'b1;
            r_err_got   <= '0;
            r_err_exp   <= '0;
        end else if (clear) begin
            r_cap_armed <= 1'b1;
            r_err_got   <= '0;
            r_err_exp   <= '0;
        end else if (w_new_lock) begin
            r_cap_armed <= 1'b1;
        end else if (w_err_hit && r_cap_armed) begin
            r_cap_armed <= 1'b0;
            r_err_got   <= in_data;
            r_err_exp   <= r_expected;
        end
    end

    assign err_got = r_err_got;
    assign err_exp = r_err_exp;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios plus a randomized run
// compared against a rule-level model of the sequence checker.
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;

    logic       in_ready, locked, err_pulse;
    logic [3:0] expected;
    logic [7:0] err_count;

    logic       s_in_ready, s_locked, s_err_pulse;
    logic [3:0] s_expected;
    logic [1:0] s_err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Rule-level reference model (mode: 0 idle, 1 acquiring, 2 locked)
    int m_mode, m_exp, m_good, m_bad, m_cnt, m_pulse, m_ready;

    always #5 clk = ~clk;

    seq_checker dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .locked(locked), .expected(expected),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    seq_checker #(.ERR_CNT_W(2), .LOSS_THRESH(15)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .locked(s_locked), .expected(s_expected),
        .err_pulse(s_err_pulse), .err_count(s_err_count)
    );

    function automatic void model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_pulse = 0; m_ready = 0;
    endfunction

    function automatic void model_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (c) begin
            m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0;
        end else if (v && m_ready != 0) begin
            if (m_mode == 0) begin
                m_exp = (d + 1) % 16; m_good = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_good = m_good + 1;
                    if (m_good == 2) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_good = 0;
                end
                m_exp = (d + 1) % 16;
            end else begin
                if (d == m_exp) begin
                    m_bad = 0;
                    m_exp = (m_exp + 1) % 16;
                end else begin
                    m_pulse = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_bad = m_bad + 1;
                    if (m_bad == 3) begin
                        m_mode = 1; m_good = 0; m_bad = 0; m_exp = (d + 1) % 16;
                    end else begin
                        m_exp = (m_exp + 1) % 16;
                    end
                end
            end
        end
        m_ready = 1;
    endfunction

    function automatic logic [14:0] model_vec();
        return {1'(m_ready), 1'(m_mode == 2), 4'(m_exp), 1'(m_pulse), 8'(m_cnt)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {in_ready, locked, expected, err_pulse, err_count};
    endfunction

    task automatic drive(input bit v, input int d, input bit c);
        @(negedge clk);
        in_valid = v; in_data = 4'(d); clear = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        $display("txn v=%0d d=%0d clr=%0d -> rdy=%0d lock=%0d exp=%0d pulse=%0d cnt=%0d",
                 v, d, c, in_ready, locked, expected, err_pulse, err_count);
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 4'd3;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 15'd0) begin
            n_fail++; $display("FAIL reset_hold: got %h need %h", dut_vec(), 15'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_step(1'b1, 3, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b1 || expected !== 4'd0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%0d exp=%0d lock=%0d need rdy=1 exp=0 lock=0",
                     in_ready, expected, locked);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_lock_in();
        int seq[3] = '{3, 4, 5};
        for (int i = 0; i < 3; i++) begin
            drive(1, seq[i], 0);
            n_cmp++;
            if (dut_vec() !== model_vec() || err_pulse !== 1'b0) begin
                n_fail++; $display("FAIL lock_in[%0d]: got %h need %h", i, dut_vec(), model_vec());
            end
            if (i == 0) begin
                n_cmp++;
                if (expected !== 4'd4 || locked !== 1'b0) begin
                    n_fail++; $display("FAIL lock_in_first: exp=%0d lock=%0d need 4/0", expected, locked);
                end
            end
        end
        n_cmp++;
        if (locked !== 1'b1 || expected !== 4'd6) begin
            n_fail++; $display("FAIL lock_in_done: lock=%0d exp=%0d need 1/6", locked, expected);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] cnt_before;
        cnt_before = err_count;
        for (int v = 6; v < 18; v++) begin
            drive(1, v % 16, 0);
            n_cmp++;
            if (dut_vec() !== model_vec() || err_pulse !== 1'b0) begin
                n_fail++; $display("FAIL wrap[%0d]: got %h need %h", v % 16, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (expected !== 4'd2 || err_count !== cnt_before || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end: exp=%0d cnt=%0d lock=%0d need 2/%0d/1", expected, err_count, locked, cnt_before);
        end
    endtask

    task automatic relock_at_6();
        drive(0, 0, 1);
        drive(1, 3, 0); drive(1, 4, 0); drive(1, 5, 0);
    endtask

    task automatic test_single_error();
        relock_at_6();
        drive(1, 9, 0);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || expected !== 4'd7 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err: pulse=%0d cnt=%0d exp=%0d lock=%0d need 1/1/7/1",
                     err_pulse, err_count, expected, locked);
        end
        drive(1, 7, 0);
        n_cmp++;
        if (err_pulse !== 1'b0 || err_count !== 8'd1 || expected !== 4'd8) begin
            n_fail++; $display("FAIL single_err_match: pulse=%0d cnt=%0d exp=%0d need 0/1/8", err_pulse, err_count, expected);
        end
        // Two more mismatches must not drop lock once bad_run was cleared.
        drive(1, 0, 0); drive(1, 0, 0);
        n_cmp++;
        if (locked !== 1'b1 || err_count !== 8'd3 || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL bad_run_cleared: got %h need %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_loss_of_lock();
        relock_at_6();
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 0);
            n_cmp++;
            if (err_pulse !== 1'b1 || err_count !== 8'(i + 1)) begin
                n_fail++; $display("FAIL loss_err[%0d]: pulse=%0d cnt=%0d need 1/%0d", i, err_pulse, err_count, i + 1);
            end
        end
        n_cmp++;
        if (locked !== 1'b0 || expected !== 4'd10) begin
            n_fail++; $display("FAIL loss_drop: lock=%0d exp=%0d need 0/10", locked, expected);
        end
        drive(1, 10, 0);
        drive(1, 11, 0);
        n_cmp++;
        if (locked !== 1'b1 || expected !== 4'd12 || err_count !== 8'd3 || err_pulse !== 1'b0) begin
            n_fail++; $display("FAIL relock: lock=%0d exp=%0d cnt=%0d need 1/12/3", locked, expected, err_count);
        end
    endtask

    task automatic test_clear();
        drive(1, 5, 1);
        n_cmp++;
        if (locked !== 1'b0 || expected !== 4'd0 || err_count !== 8'd0 || err_pulse !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear: lock=%0d exp=%0d cnt=%0d pulse=%0d rdy=%0d need 0/0/0/0/1",
                     locked, expected, err_count, err_pulse, in_ready);
        end
        drive(1, 7, 0);
        n_cmp++;
        if (expected !== 4'd8 || locked !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle: exp=%0d lock=%0d need 8/0", expected, locked);
        end
    endtask

    task automatic test_saturation();
        drive(0, 0, 1);
        drive(1, 3, 0); drive(1, 4, 0); drive(1, 5, 0);
        n_cmp++;
        if (s_locked !== 1'b1) begin
            n_fail++; $display("FAIL sat_lock: lock=%0d need 1", s_locked);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1, 9, 0);
            n_cmp++;
            if (s_err_count !== 2'((i < 3) ? i : 3) || s_locked !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_cnt[%0d]: cnt=%0d lock=%0d need %0d/1", i, s_err_count, s_locked, (i < 3) ? i : 3);
            end
        end
    endtask

    task automatic test_random();
        int d;
        bit v, c;
        drive(0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            d = ($urandom_range(0, 4) != 0) ? m_exp : int'($urandom_range(0, 15));
            drive(v, d, c);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h need %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset_midstream();
        relock_at_6();
        drive(1, 9, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd7;
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== 15'd0) begin
            n_fail++; $display("FAIL reset_async: got %h need %h", dut_vec(), 15'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        drive(0, 0, 0);
        drive(1, 2, 0);
        n_cmp++;
        if (dut_vec() !== model_vec() || expected !== 4'd3) begin
            n_fail++; $display("FAIL reset_resume: got %h need %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_lock_in();
        test_wrap();
        test_single_error();
        test_loss_of_lock();
        test_clear();
        test_saturation();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
